// File: rtl/sample_hold_pkg.sv
// Shared definitions for the sample/hold bank.
//   MODE_*       : encodings of the global capture mode input
//   snap_state_t : readout FSM states
//   chan_bits()  : width of a channel index (at least one bit)
package sample_hold_pkg;

   localparam logic [1:0] MODE_FOLLOW  = 2'b00;
   localparam logic [1:0] MODE_ONESHOT = 2'b01;
   localparam logic [1:0] MODE_FREEZE  = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } snap_state_t;

   function automatic int chan_bits(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sample_hold_chan.sv
// One sample/hold channel with a one-shot lock flag.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : capture enable for this channel
//   mode       : global capture mode (FOLLOW / ONESHOT / FREEZE)
//   clear      : clears the lock flag (never touches q)
//   d          : sample input
//   q          : held value
//   locked     : set by the first ONESHOT capture, cleared by clear
module sample_hold_chan
   import sample_hold_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [1:0]       mode,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             locked
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q      <= '0;
         locked <= 1'b0;
      end else begin
         if (clear)
            locked <= 1'b0;
         case (mode)
            MODE_FOLLOW: begin
               if (ena)
                  q <= d;
            end
            MODE_ONESHOT: begin
               // clear beats a same-edge capture: the lock drops and q keeps its value
               if (ena && !locked && !clear) begin
                  q      <= d;
                  locked <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sample_hold_bank.sv
// Bank of CHANNELS sample/hold channels plus a snapshot readout.
// A snapshot request copies every held value into a shadow array and
// streams it out one channel per valid/ready beat, so live captures can
// keep running while the readout drains.
//
// state | meaning
// IDLE  | no readout in progress, waiting for snap_req
// SEND  | presenting shadow[snap_chan] with snap_valid high
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   ena         : per-channel capture enable
//   mode        : global capture mode
//   clear       : clears all lock flags
//   in / out    : packed channel samples / held values, channel i at [i*WIDTH +: WIDTH]
//   locked      : per-channel one-shot lock flags
//   snap_req    : start a snapshot (honoured in IDLE only)
//   snap_valid, snap_ready, snap_data, snap_chan : readout beat handshake
//   snap_busy   : readout in progress
module sample_hold_bank
   import sample_hold_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CHANNELS-1:0]            ena,
   input  logic [1:0]                     mode,
   input  logic                           clear,
   input  logic [CHANNELS*WIDTH-1:0]      in,
   output logic [CHANNELS*WIDTH-1:0]      out,
   output logic [CHANNELS-1:0]            locked,
   input  logic                           snap_req,
   output logic                           snap_valid,
   input  logic                           snap_ready,
   output logic [WIDTH-1:0]               snap_data,
   output logic [chan_bits(CHANNELS)-1:0] snap_chan,
   output logic                           snap_busy
);

   localparam int                CW        = chan_bits(CHANNELS);
   localparam logic [CW-1:0]     LAST_CHAN = CW'(CHANNELS - 1);

   snap_state_t      state;
   logic [WIDTH-1:0] shadow [CHANNELS];

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      sample_hold_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .ena    (ena[g]),
         .mode   (mode),
         .clear  (clear),
         .d      (in[g*WIDTH +: WIDTH]),
         .q      (out[g*WIDTH +: WIDTH]),
         .locked (locked[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         snap_chan <= '0;
         for (int i = 0; i < CHANNELS; i++)
            shadow[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (snap_req) begin
                  // out here is the value registered before this edge's captures
                  for (int i = 0; i < CHANNELS; i++)
                     shadow[i] <= out[i*WIDTH +: WIDTH];
                  snap_chan <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (snap_ready) begin
                  if (snap_chan == LAST_CHAN)
                     state <= IDLE;
                  else
                     snap_chan <= snap_chan + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign snap_valid = (state == SEND);
   assign snap_busy  = (state != IDLE);
   assign snap_data  = snap_valid ? shadow[snap_chan] : '0;

endmodule

// File: tb/tb_sample_hold_bank.sv
module tb_sample_hold_bank;

   localparam int W = 4;
   localparam int C = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [C-1:0]  ena;
   logic [1:0]    mode;
   logic          clear;
   logic [C*W-1:0] din;
   logic [C*W-1:0] dout;
   logic [C-1:0]  locked;
   logic          snap_req;
   logic          snap_valid;
   logic          snap_ready;
   logic [W-1:0]  snap_data;
   logic [1:0]    snap_chan;
   logic          snap_busy;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [C*W-1:0] m_out;
   logic [C-1:0]   m_lock;
   logic           m_busy;
   int             m_left;
   int             beats;
   logic [5:0]     exp_q [$];   // {chan[1:0], data[3:0]}

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   sample_hold_bank #(
      .WIDTH    (W),
      .CHANNELS (C)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .mode       (mode),
      .clear      (clear),
      .in         (din),
      .out        (dout),
      .locked     (locked),
      .snap_req   (snap_req),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .snap_data  (snap_data),
      .snap_chan  (snap_chan),
      .snap_busy  (snap_busy)
   );

   // One clock: pre-edge checks against the model, model update, then the edge.
   task automatic cycle();
      logic [C*W-1:0] n_out;
      logic [C-1:0]   n_lock;
      logic [5:0]     e;
      @(negedge clk);
      checks++;
      if (dout !== m_out) begin
         errors++;
         $display("FAIL out: got %h expected %h", dout, m_out);
      end
      checks++;
      if (locked !== m_lock) begin
         errors++;
         $display("FAIL locked: got %b expected %b", locked, m_lock);
      end
      checks++;
      if (snap_busy !== m_busy || snap_valid !== m_busy) begin
         errors++;
         $display("FAIL busy_valid: got busy=%b valid=%b expected %b", snap_busy, snap_valid, m_busy);
      end
      if (m_busy && snap_ready && rst_n) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got chan=%0d data=%h expected no beat", snap_chan, snap_data);
         end else begin
            e = exp_q.pop_front();
            beats++;
            if ({snap_chan, snap_data} !== e) begin
               errors++;
               $display("FAIL beat: got chan=%0d data=%h expected chan=%0d data=%h",
                        snap_chan, snap_data, e[5:4], e[3:0]);
            end
         end
      end
      if (!rst_n) begin
         m_out  = '0;
         m_lock = '0;
         m_busy = 1'b0;
         m_left = 0;
         exp_q.delete();
      end else begin
         if (!m_busy && snap_req) begin
            for (int i = 0; i < C; i++)
               exp_q.push_back({i[1:0], m_out[i*W +: W]});
            m_busy = 1'b1;
            m_left = C;
         end else if (m_busy && snap_ready) begin
            m_left--;
            if (m_left == 0)
               m_busy = 1'b0;
         end
         n_out  = m_out;
         n_lock = clear ? '0 : m_lock;
         for (int i = 0; i < C; i++) begin
            if (mode == 2'b00 && ena[i])
               n_out[i*W +: W] = din[i*W +: W];
            else if (mode == 2'b01 && ena[i] && !m_lock[i] && !clear) begin
               n_out[i*W +: W] = din[i*W +: W];
               n_lock[i] = 1'b1;
            end
         end
         m_out  = n_out;
         m_lock = n_lock;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = '1; mode = 2'b00; clear = 1'b0; din = 16'hFFFF;
      snap_req = 1'b1; snap_ready = 1'b1;
      m_out = '0; m_lock = '0; m_busy = 1'b0; m_left = 0; beats = 0;
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 16'h0 || locked !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: got out=%h locked=%b expected 0000/0000", dout, locked);
      end
      checks++;
      if (snap_valid !== 1'b0 || snap_busy !== 1'b0 || snap_chan !== 2'd0 || snap_data !== 4'h0) begin
         errors++;
         $display("FAIL reset_snap: got valid=%b busy=%b chan=%0d data=%h expected 0/0/0/0",
                  snap_valid, snap_busy, snap_chan, snap_data);
      end
      cycle();
      rst_n = 1'b1; ena = '0; snap_req = 1'b0; din = '0;
      cycle();
   endtask

   task automatic test_follow();
      mode = 2'b00; din = 16'h4321; ena = 4'b0101;
      cycle();
      ena = '0; din = 16'h9999;
      cycle();
      checks++;
      if (dout !== 16'h0301) begin
         errors++;
         $display("FAIL follow: got %h expected 0301", dout);
      end
      ena = 4'b1010; din = 16'h7E5C;
      cycle();
      ena = '0;
      cycle();
      checks++;
      if (dout !== 16'h7351) begin
         errors++;
         $display("FAIL follow_2: got %h expected 7351", dout);
      end
   endtask

   task automatic test_oneshot();
      mode = 2'b01; ena = 4'b0001;
      for (int v = 5; v <= 7; v++) begin
         din = {12'h000, 4'(v)};
         cycle();
      end
      ena = '0;
      cycle();
      checks++;
      if (dout[3:0] !== 4'h5 || locked[0] !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_lock: got out0=%h locked0=%b expected 5/1", dout[3:0], locked[0]);
      end
      clear = 1'b1;
      cycle();
      clear = 1'b0; ena = 4'b0001; din = 16'h0009;
      cycle();
      ena = '0;
      cycle();
      checks++;
      if (dout[3:0] !== 4'h9 || locked !== 4'b0001) begin
         errors++;
         $display("FAIL oneshot_relock: got out0=%h locked=%b expected 9/0001", dout[3:0], locked);
      end
   endtask

   task automatic test_clear_vs_ena();
      logic [3:0] prev;
      prev = dout[7:4];
      mode = 2'b01; clear = 1'b1; ena = 4'b0010; din = 16'h00A0;
      cycle();
      clear = 1'b0; ena = '0;
      cycle();
      checks++;
      if (locked[1] !== 1'b0 || dout[7:4] !== prev) begin
         errors++;
         $display("FAIL clear_vs_ena: got locked1=%b out1=%h expected 0/%h", locked[1], dout[7:4], prev);
      end
   endtask

   task automatic test_freeze();
      logic [15:0] prev;
      mode = 2'b01; ena = 4'b1000; din = 16'hB000;
      cycle();
      prev = dout;
      mode = 2'b10; ena = '1; din = 16'h1234;
      cycle();
      mode = 2'b11;
      cycle();
      checks++;
      if (dout !== prev || locked !== 4'b1000) begin
         errors++;
         $display("FAIL freeze: got out=%h locked=%b expected %h/1000", dout, locked, prev);
      end
      clear = 1'b1;
      cycle();
      clear = 1'b0; ena = '0;
      cycle();
      checks++;
      if (dout !== prev || locked !== 4'b0000) begin
         errors++;
         $display("FAIL freeze_clear: got out=%h locked=%b expected %h/0000", dout, locked, prev);
      end
   endtask

   task automatic test_snapshot();
      mode = 2'b00; ena = '1; din = 16'hDCBA;
      cycle();
      ena = '0; din = 16'h0000;
      beats = 0;
      snap_req = 1'b1; snap_ready = 1'b1;
      cycle();
      // request stays high through the readout and its final edge
      for (int k = 0; k < C; k++)
         cycle();
      snap_req = 1'b0;
      checks++;
      if (beats !== C || snap_busy !== 1'b0) begin
         errors++;
         $display("FAIL snapshot: got beats=%0d busy=%b expected %0d/0", beats, snap_busy, C);
      end
      cycle();
   endtask

   task automatic test_backpressure();
      snap_req = 1'b1; snap_ready = 1'b1;
      cycle();
      snap_req = 1'b0;
      cycle();
      snap_ready = 1'b0; mode = 2'b00; ena = 4'b0010; din = 16'h0000;
      cycle();
      ena = '0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (snap_chan !== 2'd1 || snap_data !== 4'hB || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: got chan=%0d data=%h valid=%b expected 1/b/1",
                     snap_chan, snap_data, snap_valid);
         end
         cycle();
      end
      snap_ready = 1'b1;
      for (int k = 0; k < 3; k++)
         cycle();
      cycle();
   endtask

   task automatic test_reset_mid_send();
      mode = 2'b01; ena = 4'b0100; din = 16'h0600;
      cycle();
      ena = '0;
      snap_req = 1'b1; snap_ready = 1'b1;
      cycle();
      snap_req = 1'b0;
      cycle();
      cycle();
      checks++;
      if (snap_chan !== 2'd2 || snap_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_send_pos: got chan=%0d valid=%b expected 2/1", snap_chan, snap_valid);
      end
      rst_n = 1'b0; ena = '1; clear = 1'b0; snap_req = 1'b1; din = 16'hFFFF;
      cycle();
      checks++;
      if (snap_valid !== 1'b0 || dout !== 16'h0 || locked !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_send: got valid=%b out=%h locked=%b expected 0/0000/0000",
                  snap_valid, dout, locked);
      end
      rst_n = 1'b1; ena = '0; snap_req = 1'b0;
      for (int k = 0; k < 3; k++)
         cycle();
   endtask

   initial begin
      test_reset();
      test_follow();
      test_oneshot();
      test_clear_vs_ena();
      test_freeze();
      test_snapshot();
      test_backpressure();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
